// File: rtl/ids_pim_pkg.sv
// ids_pim_pkg
// Shared definitions for the PIM command queue:
//   - funct3 encodings of the three PIM custom instructions
//   - pim_cmd_t: packed 52-bit command {funct3, sel_pim, size, mem_addr}
//   - pim_state_e: issue FSM states
//   - cmd_legal(): push-time command validation
package ids_pim_pkg;

   localparam logic [2:0] PIM_WRITE   = 3'b001;
   localparam logic [2:0] PIM_COMPUTE = 3'b010;
   localparam logic [2:0] PIM_LOAD    = 3'b100;

   typedef struct packed {
      logic [2:0]  funct3;
      logic [3:0]  sel_pim;
      logic [12:0] size;
      logic [31:0] mem_addr;
   } pim_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } pim_state_e;

   // A command is worth storing only if it names a known operation and
   // actually moves data.
   function automatic logic cmd_legal(input pim_cmd_t cmd);
      return ((cmd.funct3 == PIM_WRITE) ||
              (cmd.funct3 == PIM_COMPUTE) ||
              (cmd.funct3 == PIM_LOAD)) && (cmd.size != 13'd0);
   endfunction

endpackage

// File: rtl/ids_sync_fifo.sv
// ids_sync_fifo
// Single-clock FIFO with extended (one extra MSB) read/write pointers.
// All status outputs derive from registered pointers only.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   push, wdata     write request / data (ignored when full)
//   pop             read request (ignored when empty)
//   rdata           head entry (valid when !empty)
//   full, empty     status
//   count           number of stored entries, 0..DEPTH
module ids_sync_fifo #(
   parameter int WIDTH = 52,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Same index with differing wrap bits means the writer lapped the reader.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ids_pim_cmd_queue.sv
// ids_pim_cmd_queue
// Buffers PIM commands from the core decode stage and issues them one at a
// time to the PIM DMA engine, retiring each when DMA busy falls.
// Optional macro IDS_CMDQ_PERF_EN adds retire / busy-cycle counters.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake; transfer when both high.
//                             Ready is !full of the registered FIFO state.
//   i_cmd_funct3/sel_pim/size/mem_addr   command fields
//   o_dma_en                  one-cycle issue pulse
//   o_funct3/sel_pim/size/mem_addr       head operands, 0 when idle
//   i_dma_busy                DMA busy status
//   o_idle                    FSM idle and FIFO empty
//   o_err, i_err_clr          sticky error (illegal push / start timeout), clear
//   o_perf_cmds, o_perf_busy_cycles   (IDS_CMDQ_PERF_EN only)
module ids_pim_cmd_queue
   import ids_pim_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int START_TIMEOUT = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [2:0]  i_cmd_funct3,
   input  logic [3:0]  i_cmd_sel_pim,
   input  logic [12:0] i_cmd_size,
   input  logic [31:0] i_cmd_mem_addr,
   output logic        o_dma_en,
   output logic [2:0]  o_funct3,
   output logic [3:0]  o_sel_pim,
   output logic [12:0] o_size,
   output logic [31:0] o_mem_addr,
   input  logic        i_dma_busy,
   output logic        o_idle,
   output logic        o_err,
   input  logic        i_err_clr
`ifdef IDS_CMDQ_PERF_EN
   ,
   output logic [31:0] o_perf_cmds,
   output logic [31:0] o_perf_busy_cycles
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(START_TIMEOUT + 1);
   localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] TO_ONE  = CW'(1);

   pim_cmd_t    cmd_in;
   pim_cmd_t    head;
   logic        fifo_full;
   logic        fifo_empty;
   logic [AW:0] fifo_count;
   logic        accept;
   logic        legal;
   logic        fifo_push;
   logic        fifo_pop;
   logic        timeout_hit;
   logic        retire;
   logic        more_after_pop;

   pim_state_e  state;
   logic [CW-1:0] to_cnt;
   logic        dma_en_q;
   logic        err_q;

   assign cmd_in = {i_cmd_funct3, i_cmd_sel_pim, i_cmd_size, i_cmd_mem_addr};

   // Illegal commands still complete the handshake; they just never reach
   // the FIFO.
   assign o_cmd_ready = !fifo_full;
   assign accept      = i_cmd_valid && !fifo_full;
   assign legal       = cmd_legal(cmd_in);
   assign fifo_push   = accept && legal;

   assign timeout_hit = (state == ST_WAIT_START) && !i_dma_busy && (to_cnt == TO_LAST);
   assign retire      = (state == ST_WAIT_DONE) && !i_dma_busy;
   assign fifo_pop    = timeout_hit || retire;

   // A same-cycle push refills the queue even when the last entry retires.
   assign more_after_pop = (fifo_count > CNT_ONE) || fifo_push;

   ids_sync_fifo #(
      .WIDTH ($bits(pim_cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (fifo_push),
      .wdata (cmd_in),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Issue FSM. dma_en_q is raised together with every entry into ISSUE so
   // it is high exactly for the ISSUE cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         to_cnt   <= '0;
         dma_en_q <= 1'b0;
      end else begin
         dma_en_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty && !i_dma_busy) begin
                  state    <= ST_ISSUE;
                  dma_en_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               to_cnt <= '0;
               state  <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (i_dma_busy)
                  state <= ST_WAIT_DONE;
               else if (to_cnt == TO_LAST)
                  state <= ST_IDLE;
               else
                  to_cnt <= to_cnt + TO_ONE;
            end
            ST_WAIT_DONE: begin
               if (!i_dma_busy) begin
                  if (more_after_pop) begin
                     state    <= ST_ISSUE;
                     dma_en_q <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Set has priority so an error coincident with a clear is not lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         err_q <= 1'b0;
      else if ((accept && !legal) || timeout_hit)
         err_q <= 1'b1;
      else if (i_err_clr)
         err_q <= 1'b0;
   end

   assign o_dma_en   = dma_en_q;
   assign o_err      = err_q;
   assign o_idle     = (state == ST_IDLE) && fifo_empty;

   // The head is stable from issue to retire because pushes never touch a
   // non-empty head slot.
   assign o_funct3   = (state != ST_IDLE) ? head.funct3   : 3'b0;
   assign o_sel_pim  = (state != ST_IDLE) ? head.sel_pim  : 4'b0;
   assign o_size     = (state != ST_IDLE) ? head.size     : 13'b0;
   assign o_mem_addr = (state != ST_IDLE) ? head.mem_addr : 32'b0;

`ifdef IDS_CMDQ_PERF_EN
   logic [31:0] perf_cmds_q;
   logic [31:0] perf_busy_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_cmds_q <= '0;
         perf_busy_q <= '0;
      end else begin
         if (retire)
            perf_cmds_q <= perf_cmds_q + 32'd1;
         if (state == ST_WAIT_DONE)
            perf_busy_q <= perf_busy_q + 32'd1;
      end
   end

   assign o_perf_cmds        = perf_cmds_q;
   assign o_perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_ids_pim_cmd_queue.sv
// tb_ids_pim_cmd_queue
// Scoreboard bench: every accepted legal command is queued as the expected
// issue; a monitor pops and compares on each o_dma_en pulse. A DMA model
// answers issues with a programmable busy window.
`timescale 1ns/1ps
module tb_ids_pim_cmd_queue;

   localparam int DEPTH         = 4;
   localparam int START_TIMEOUT = 8;
   localparam int BUDGET        = 400;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_funct3;
   logic [3:0]  cmd_sel_pim;
   logic [12:0] cmd_size;
   logic [31:0] cmd_mem_addr;
   logic        dma_en;
   logic [2:0]  funct3;
   logic [3:0]  sel_pim;
   logic [12:0] size;
   logic [31:0] mem_addr;
   logic        dma_busy;
   logic        idle;
   logic        err;
   logic        err_clr;
`ifdef IDS_CMDQ_PERF_EN
   logic [31:0] perf_cmds;
   logic [31:0] perf_busy_cycles;
`endif

   logic [51:0] ops;
   assign ops = {funct3, sel_pim, size, mem_addr};

   ids_pim_cmd_queue #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_cmd_valid    (cmd_valid),
      .o_cmd_ready    (cmd_ready),
      .i_cmd_funct3   (cmd_funct3),
      .i_cmd_sel_pim  (cmd_sel_pim),
      .i_cmd_size     (cmd_size),
      .i_cmd_mem_addr (cmd_mem_addr),
      .o_dma_en       (dma_en),
      .o_funct3       (funct3),
      .o_sel_pim      (sel_pim),
      .o_size         (size),
      .o_mem_addr     (mem_addr),
      .i_dma_busy     (dma_busy),
      .o_idle         (idle),
      .o_err          (err),
      .i_err_clr      (err_clr)
`ifdef IDS_CMDQ_PERF_EN
      ,
      .o_perf_cmds        (perf_cmds),
      .o_perf_busy_cycles (perf_busy_cycles)
`endif
   );

   // ---------------- scoreboard state ----------------
   int tests_run = 0;
   int tests_failed = 0;
   logic [51:0] exp_q[$];
   int en_count = 0;
   int last_en_cyc = 0;
   int push_cyc = 0;
   int busy_fall_cyc = -1;
   logic prev_en = 1'b0;
   logic prev_busy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- DMA model ----------------
   // Busy rises one cycle after the issue pulse and stays high dma_hold
   // cycles. dma_force holds busy high regardless; dma_respond=0 ignores issues.
   logic dma_respond = 1'b1;
   logic dma_force = 1'b0;
   logic dma_busy_m = 1'b0;
   int   dma_hold = 6;
   assign dma_busy = dma_busy_m | dma_force;

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rst_n && dma_en && dma_respond) begin
            @(posedge clk); #1;
            dma_busy_m = 1'b1;
            for (int k = 0; k < dma_hold && rst_n; k++) begin
               @(posedge clk); #1;
            end
            dma_busy_m = 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (dma_en) begin
            en_count++;
            last_en_cyc = cyc;
            check("en_while_busy", dma_busy, 0);
            check("en_single_cycle", prev_en, 0);
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_issue: got 0x%0h, expected no issue", ops);
            end else begin
               check("issue_operands", ops, exp_q.pop_front());
            end
         end
         if (idle)
            check("idle_operands_zero", ops, 0);
      end
      if (prev_busy && !dma_busy)
         busy_fall_cyc = cyc;
      prev_en = dma_en;
      prev_busy = dma_busy;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk); #1;
   endtask

   function automatic logic model_legal(input logic [2:0] f, input logic [12:0] sz);
      return (f == 3'b001 || f == 3'b010 || f == 3'b100) && (sz != 13'd0);
   endfunction

   task automatic push_cmd(input logic [2:0] f, input logic [3:0] s, input logic [12:0] sz,
                           input logic [31:0] a, input logic clr);
      int n = 0;
      cmd_valid    = 1'b1;
      cmd_funct3   = f;
      cmd_sel_pim  = s;
      cmd_size     = sz;
      cmd_mem_addr = a;
      err_clr      = clr;
      while (!cmd_ready && n < BUDGET) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL push_ready_timeout: got ready=0, expected ready within %0d cycles", BUDGET);
         cmd_valid = 1'b0;
         err_clr = 1'b0;
         return;
      end
      push_cyc = cyc;
      if (model_legal(f, sz))
         exp_q.push_back({f, s, sz, a});
      tick();
      cmd_valid = 1'b0;
      err_clr = 1'b0;
      if (!model_legal(f, sz))
         check("illegal_sets_err", err, 1);
   endtask

   task automatic push_rand_legal();
      logic [2:0] f;
      int r = $urandom_range(0, 2);
      f = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : 3'b100;
      push_cmd(f, 4'($urandom_range(0, 15)), 13'($urandom_range(1, 8191)), $urandom, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!idle && n < BUDGET) begin
         tick();
         n++;
      end
      check(name, idle, 1);
   endtask

   task automatic wait_en(input int base, input string name);
      int n = 0;
      while (en_count == base && n < BUDGET) begin
         tick();
         n++;
      end
      check(name, en_count != base, 1);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base;
      int n;
      int en_c;
      int err_c;
      logic [2:0] f;
      logic [12:0] sz;
`ifdef IDS_CMDQ_PERF_EN
      logic [31:0] p_cmds0;
      logic [31:0] p_busy0;
`endif
      cmd_valid = 1'b0;
      cmd_funct3 = '0;
      cmd_sel_pim = '0;
      cmd_size = '0;
      cmd_mem_addr = '0;
      err_clr = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_ready", cmd_ready, 1);
      check("rst_idle", idle, 1);
      check("rst_dma_en", dma_en, 0);
      check("rst_err", err, 0);
      check("rst_operands", ops, 0);
      rst_n = 1'b1;
      tick();

      // Single command: latency, operand hold, idle after retire
      base = en_count;
      push_cmd(3'b001, 4'd3, 13'd4, 32'h100, 1'b0);
      wait_en(base, "t1_issue_seen");
      check("t1_latency", last_en_cyc - push_cyc, 2);
      n = 0;
      while (!dma_busy && n < BUDGET) begin tick(); n++; end
      while (dma_busy && n < BUDGET) begin
         check("t1_operands_held", ops, {3'b001, 4'd3, 13'd4, 32'h100});
         tick();
         n++;
      end
      check("t1_busy_window_seen", n < BUDGET, 1);
      check("t1_not_idle_at_retire", idle, 0);
      tick();
      check("t1_idle_after_retire", idle, 1);
      check("t1_single_issue", en_count - base, 1);

`ifdef IDS_CMDQ_PERF_EN
      p_cmds0 = perf_cmds;
      p_busy0 = perf_busy_cycles;
      repeat (3) push_rand_legal();
      wait_idle("perf_drain");
      check("perf_cmds", perf_cmds - p_cmds0, 3);
      check("perf_busy_cycles", perf_busy_cycles - p_busy0, 18);
`endif

      // Back-pressure: 5 commands into a 4-deep queue while DMA is busy
      dma_force = 1'b1;
      tick();
      repeat (DEPTH) push_rand_legal();
      check("t2_full_not_ready", cmd_ready, 0);
      fork
         push_rand_legal();
         begin
            repeat (3) tick();
            dma_force = 1'b0;
         end
      join
      check("t2_fifth_after_retire", push_cyc, busy_fall_cyc + 1);
      wait_idle("t2_drain");
      check("t2_all_issued", exp_q.size(), 0);

      // Illegal commands, sticky error, clear, set-over-clear
      base = en_count;
      push_cmd(3'b011, 4'd1, 13'd8, 32'h200, 1'b0);
      push_cmd(3'b010, 4'd2, 13'd0, 32'h300, 1'b0);
      pulse_clr();
      check("t3_err_cleared", err, 0);
      push_cmd(3'b111, 4'd5, 13'd9, 32'h400, 1'b1);
      pulse_clr();
      check("t3_err_cleared_again", err, 0);
      push_cmd(3'b100, 4'd7, 13'd16, 32'h500, 1'b0);
      wait_idle("t3_drain");
      check("t3_only_legal_issued", en_count - base, 1);

      // Start timeout
      dma_respond = 1'b0;
      base = en_count;
      push_cmd(3'b010, 4'd4, 13'd32, 32'h600, 1'b0);
      push_cmd(3'b001, 4'd6, 13'd2, 32'h700, 1'b0);
      wait_en(base, "t4_issue_seen");
      en_c = last_en_cyc;
      n = 0;
      while (!err && n < BUDGET) begin tick(); n++; end
      err_c = cyc;
      dma_respond = 1'b1;
      check("t4_err_set", err, 1);
      check("t4_timeout_cycles", err_c - en_c, START_TIMEOUT + 1);
      wait_idle("t4_drain");
      check("t4_both_issued", en_count - base, 2);
      pulse_clr();
      check("t4_err_cleared", err, 0);

      // Reset during WAIT_DONE with 3 entries queued
      dma_hold = 30;
      base = en_count;
      push_rand_legal();
      wait_en(base, "t5_issue_seen");
      repeat (3) push_rand_legal();
      n = 0;
      while (!dma_busy && n < BUDGET) begin tick(); n++; end
      repeat (2) tick();
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t5_rst_dma_en", dma_en, 0);
      check("t5_rst_idle", idle, 1);
      check("t5_rst_ready", cmd_ready, 1);
      check("t5_rst_operands", ops, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      base = en_count;
      repeat (20) tick();
      check("t5_no_issue_after_reset", en_count - base, 0);
      check("t5_idle_after_reset", idle, 1);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         int r = $urandom_range(0, 9);
         f = (r < 3) ? 3'b001 : (r < 6) ? 3'b010 : (r < 9) ? 3'b100 : 3'($urandom_range(0, 7));
         sz = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
         dma_hold = $urandom_range(1, 5);
         push_cmd(f, 4'($urandom_range(0, 15)), sz, $urandom, 1'b0);
         if (err && ($urandom_range(0, 1) == 1))
            pulse_clr();
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle("rand_drain");
      check("rand_all_issued", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ids_pim_cmd_queue.md
Name: ids_pim_cmd_queue

Overview:
- Upstream feeder of the PIM DMA engine.
- Accepts PIM commands (write-weight / compute / load) from the core's custom-instruction decode stage and buffers them in a small FIFO.
- Issues them one at a time to the DMA using its enable/operand interface, and tracks DMA busy to know when each command retires.
- Gives the core back-pressure and an all-idle indication so fence-style instructions can stall until PIM traffic drains.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- START_TIMEOUT, 8, cycles to wait for DMA busy to rise after issue before declaring a start failure.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  core presents a command
- o_cmd_ready  out  1  queue can accept; equals !full, registered-state only
- i_cmd_funct3  in  3  001 write-weight, 010 compute, 100 load
- i_cmd_sel_pim  in  4  PIM macro select
- i_cmd_size  in  13  word transfer count
- i_cmd_mem_addr  in  32  SRAM word address
- o_dma_en  out  1  one-cycle issue pulse to DMA
- o_funct3  out  3  head-of-queue funct3, held from issue until retire
- o_sel_pim  out  4  head sel_pim
- o_size  out  13  head size
- o_mem_addr  out  32  head mem_addr
- i_dma_busy  in  1  DMA busy status
- o_idle  out  1  FIFO empty and FSM in IDLE
- o_err  out  1  sticky error flag
- i_err_clr  in  1  clears o_err

Behaviour:
- Reset values:
  - all outputs 0, except o_cmd_ready=1 and o_idle=1
  - FIFO empty, FSM IDLE, timeout counter 0
- Push occurs when i_cmd_valid && o_cmd_ready.
- Push-time validation:
  - a command is legal only if funct3 ∈ {001,010,100} and size≠0
  - an illegal command is consumed (the handshake completes), not stored, and sets o_err the next cycle
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; the count saturates at DEPTH.
- Full and pop in the same cycle: o_cmd_ready stays 0 that cycle. Ready derives from registered full only; no combinational pop-to-ready path.
- Empty and push in the same cycle: the entry is visible at the head the next cycle, and IDLE sees it one cycle later. Minimum push-to-o_dma_en latency is 2 cycles.
- FSM:
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE: o_dma_en=1 for exactly one cycle, operand outputs driven from the head; timeout counter cleared → WAIT_START.
  - WAIT_START:
    - i_dma_busy=1 → WAIT_DONE
    - else the counter increments; at START_TIMEOUT: set o_err, pop head, → IDLE
  - WAIT_DONE: i_dma_busy=0 → pop head; → ISSUE if FIFO still non-empty after the pop, else IDLE.
- Operand outputs hold the head value in ISSUE, WAIT_START and WAIT_DONE. They are 0 in IDLE.
- o_dma_en is never asserted while i_dma_busy=1; ISSUE is only entered with busy low.
- o_idle = (FSM==IDLE) && empty, registered-state only.
- o_err is set by an illegal push or a start timeout.
  - i_err_clr clears it.
  - Set wins over a simultaneous clear.
- Reset mid-operation returns everything to reset values immediately. The DMA sees o_dma_en=0 and the queue contents are discarded.

Optional Feature:
- Macro: IDS_CMDQ_PERF_EN.
- When defined, adds two extra outputs:
  - o_perf_cmds (32b): commands retired normally in WAIT_DONE.
  - o_perf_busy_cycles (32b): cycles spent in WAIT_DONE.
- Both counters wrap modulo 2^32 and reset to 0. i_err_clr does not affect them.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package ids_pim_pkg holds:
  - funct3 localparams PIM_WRITE=3'b001, PIM_COMPUTE=3'b010, PIM_LOAD=3'b100
  - packed struct pim_cmd_t {funct3, sel_pim, size, mem_addr} (52 bits)
  - enum for the FSM states
- The FIFO storage and pointers form one natural sub-module, ids_sync_fifo, parameterised on width and depth, with push/pop/full/empty.
- The FSM and validation logic stay in the top module.

Test Plan:
- Single command (001, sel 3, size 4, addr 0x100) on an empty queue; DMA model raises busy 1 cycle after en, holds 6 cycles → o_dma_en pulses once 2 cycles after push; operands stable until busy falls; o_idle=1 the cycle after retire.
- Push 5 commands back-to-back with DEPTH=4 while DMA busy is held high → 4 accepted, o_cmd_ready=0 on the 5th; it is accepted the cycle after the first retire; all 5 issue in FIFO order.
- Push funct3=011, then a command with size=0 → neither issues; o_err=1 after the first push; i_err_clr → o_err=0; the next legal command issues normally.
- DMA model never asserts busy → o_err=1 exactly START_TIMEOUT cycles after the WAIT_START entry; head popped; the next queued command issues.
- Assert i_rst_n=0 during WAIT_DONE with 3 entries queued → o_dma_en=0, o_idle=1, o_cmd_ready=1; no issue after reset release.
- With IDS_CMDQ_PERF_EN defined, run 3 commands with 6 busy cycles each → o_perf_cmds=3, o_perf_busy_cycles=18.
